// File: rtl/status_array_ctrl_pkg.sv
// status_array_ctrl_pkg: shared geometry and sequencer state encoding for the status-array controller.
package status_array_ctrl_pkg;
    localparam int ADDR_WIDTH = 4;
    localparam int ROW_WIDTH  = 8;
    localparam int NUM_BLOCKS = 8;
    typedef enum logic {SWEEP = 1'b0, RUN = 1'b1} state_t;
endpackage

// File: rtl/status_req_arbiter.sv
// status_req_arbiter: lookup/update arbiter, update first, strict alternation under contention.
module status_req_arbiter (
    input  logic clk,
    input  logic srst,
    input  logic i_lk_valid,
    input  logic i_up_valid,
    input  logic i_en,
    output logic lk_grant,
    output logic up_grant
);
    logic last_up;
    always_comb begin
        up_grant = i_en && i_up_valid && (!i_lk_valid || !last_up);
        lk_grant = i_en && i_lk_valid && (!i_up_valid || last_up);
    end
    always_ff @(posedge clk) begin
        if (srst) last_up <= 1'b0;
        else if (up_grant || lk_grant) last_up <= up_grant;
    end
endmodule

// File: rtl/status_array_ctrl.sv
// status_array_ctrl: clears all status rows after reset/flush, then arbitrates lookups and updates onto the array port.
module status_array_ctrl
    import status_array_ctrl_pkg::*;
#(
    parameter int TAG_WIDTH = 1
) (
    input  logic                  clk,
    input  logic                  srst,
    input  logic                  i_lk_valid,
    input  logic [ADDR_WIDTH-1:0] i_lk_addr,
    input  logic [TAG_WIDTH-1:0]  i_lk_tag,
    output logic                  o_lk_ready,
    input  logic                  i_up_valid,
    input  logic [ADDR_WIDTH-1:0] i_up_addr,
    input  logic [ROW_WIDTH-1:0]  i_up_data,
    input  logic [NUM_BLOCKS-1:0] i_up_wmask,
    output logic                  o_up_ready,
    input  logic                  i_flush,
    output logic                  o_sa_valid,
    output logic                  o_sa_wen,
    output logic [ADDR_WIDTH-1:0] o_sa_addr,
    output logic [ROW_WIDTH-1:0]  o_sa_data,
    output logic [NUM_BLOCKS-1:0] o_sa_wmask,
    output logic [TAG_WIDTH-1:0]  o_sa_tag,
    input  logic                  i_sa_ready,
    output logic                  o_init_done,
    output logic                  o_busy
);
    state_t                state;
    logic [ADDR_WIDTH-1:0] cnt;
    logic                  flush_pend, init_done, sweep_wr, en, lk_g, up_g;
    always_comb begin
        sweep_wr = !srst && i_sa_ready && state == SWEEP;
        en       = !srst && i_sa_ready && state == RUN && !flush_pend && !i_flush;
    end
    status_req_arbiter u_arb (
        .clk       (clk),
        .srst      (srst),
        .i_lk_valid(i_lk_valid),
        .i_up_valid(i_up_valid),
        .i_en      (en),
        .lk_grant  (lk_g),
        .up_grant  (up_g)
    );
    // A flush seen while halted is remembered and acted on at the next ready cycle.
    always_ff @(posedge clk) begin
        if (srst) begin
            state      <= SWEEP;
            cnt        <= '0;
            flush_pend <= 1'b0;
            init_done  <= 1'b0;
        end else if (state == SWEEP) begin
            flush_pend <= 1'b0;
            if (i_sa_ready) begin
                cnt <= cnt + ADDR_WIDTH'(1);
                if (&cnt) begin
                    state     <= RUN;
                    init_done <= 1'b1;
                end
            end
        end else if (i_sa_ready && (flush_pend || i_flush)) begin
            state      <= SWEEP;
            flush_pend <= 1'b0;
        end else if (i_flush) begin
            flush_pend <= 1'b1;
        end
    end
    always_comb begin
        o_lk_ready  = lk_g;
        o_up_ready  = up_g;
        o_sa_valid  = sweep_wr || up_g || lk_g;
        o_sa_wen    = sweep_wr || up_g;
        o_sa_addr   = sweep_wr ? cnt : up_g ? i_up_addr : lk_g ? i_lk_addr : '0;
        o_sa_data   = up_g ? i_up_data : '0;
        o_sa_wmask  = sweep_wr ? '1 : up_g ? i_up_wmask : '0;
        o_sa_tag    = lk_g ? i_lk_tag : '0;
        o_init_done = init_done;
        o_busy      = state == SWEEP;
    end
endmodule

// File: tb/tb_status_array_ctrl.sv
// tb_status_array_ctrl: directed stimulus with a cycle-level behavioural model and a stand-in status-array memory.
module tb_status_array_ctrl;
    logic       clk = 0;
    logic       srst = 1;
    logic       lk_valid = 0, up_valid = 0, flush = 0, sa_ready = 1;
    logic [3:0] lk_addr = 0, up_addr = 0;
    logic       lk_tag = 0;
    logic [7:0] up_data = 0, up_mask = 0;
    logic       lk_ready, up_ready, sa_valid, sa_wen, sa_tag, init_done, busy;
    logic [3:0] sa_addr;
    logic [7:0] sa_data, sa_wmask;

    int checks = 0, failures = 0, nwr = 0;

    status_array_ctrl #(.TAG_WIDTH(1)) dut (
        .clk(clk), .srst(srst),
        .i_lk_valid(lk_valid), .i_lk_addr(lk_addr), .i_lk_tag(lk_tag), .o_lk_ready(lk_ready),
        .i_up_valid(up_valid), .i_up_addr(up_addr), .i_up_data(up_data), .i_up_wmask(up_mask),
        .o_up_ready(up_ready), .i_flush(flush),
        .o_sa_valid(sa_valid), .o_sa_wen(sa_wen), .o_sa_addr(sa_addr), .o_sa_data(sa_data),
        .o_sa_wmask(sa_wmask), .o_sa_tag(sa_tag), .i_sa_ready(sa_ready),
        .o_init_done(init_done), .o_busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", n, act, exp, $time);
        end
    endtask

    // Model: sweep progress as a row count, memory as a byte array, fairness as who went last.
    int         m_sweeping = 1, m_rows_done = 0, m_fp = 0, m_last_up = 0, m_init = 0;
    logic [7:0] m_mem [16];
    logic [7:0] m_lk_result = 8'hEE;
    logic       ev, ew, elr, eur, et;
    logic [3:0] ea;
    logic [7:0] ed, em;

    initial for (int i = 0; i < 16; i++) m_mem[i] = 8'hAA;

    always @(negedge clk) begin
        if (sa_valid && sa_wen) nwr++;
        {ev, ew, elr, eur, et, ea, ed, em} = '0;
        if (srst) begin
        end else if (m_sweeping != 0) begin
            if (sa_ready) begin
                ev = 1; ew = 1; ea = 4'(m_rows_done); em = 8'hFF;
            end
        end else if (sa_ready && m_fp == 0 && !flush) begin
            if (up_valid && (!lk_valid || m_last_up == 0)) begin
                eur = 1; ev = 1; ew = 1; ea = up_addr; ed = up_data; em = up_mask;
            end else if (lk_valid) begin
                elr = 1; ev = 1; ea = lk_addr; et = lk_tag;
            end
        end
        chk("lk_ready", lk_ready, elr);
        chk("up_ready", up_ready, eur);
        chk("sa_valid", sa_valid, ev);
        chk("sa_wen", sa_wen, ew);
        chk("sa_addr", sa_addr, ea);
        chk("sa_data", sa_data, ed);
        chk("sa_wmask", sa_wmask, em);
        chk("sa_tag", sa_tag, et);
        if (!srst) begin
            chk("init_done", init_done, m_init != 0);
            chk("busy", busy, m_sweeping != 0);
        end
        if (srst) begin
            m_sweeping = 1; m_rows_done = 0; m_fp = 0; m_last_up = 0; m_init = 0;
        end else if (m_sweeping != 0) begin
            m_fp = 0;
            if (sa_ready) begin
                m_mem[m_rows_done] = 8'h00;
                m_rows_done++;
                if (m_rows_done == 16) begin
                    m_rows_done = 0; m_sweeping = 0; m_init = 1;
                end
            end
        end else if (sa_ready && (m_fp != 0 || flush)) begin
            m_sweeping = 1; m_fp = 0;
        end else begin
            if (flush) m_fp = 1;
            if (eur) begin
                m_mem[up_addr] = (m_mem[up_addr] & ~up_mask) | (up_data & up_mask);
                m_last_up = 1;
            end else if (elr) begin
                m_lk_result = m_mem[lk_addr];
                m_last_up = 0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_init();
        int i;
        for (i = 0; i < 40 && !init_done; i++) step();
        chk("init_timeout", init_done, 1);
    endtask

    task automatic do_up(input logic [3:0] a, input logic [7:0] d, input logic [7:0] m);
        bit got = 0;
        up_valid = 1; up_addr = a; up_data = d; up_mask = m;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            got = up_ready;
        end
        chk("up_timeout", got, 1);
        step();
        up_valid = 0;
    endtask

    task automatic do_lk(input logic [3:0] a, input logic t);
        bit got = 0;
        lk_valid = 1; lk_addr = a; lk_tag = t;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            got = lk_ready;
            if (got) begin
                chk("lk_grant_addr", sa_addr, a);
                chk("lk_grant_tag", sa_tag, t);
                chk("lk_grant_wen", sa_wen, 0);
            end
        end
        chk("lk_timeout", got, 1);
        step();
        lk_valid = 0;
    endtask

    initial begin
        logic [3:0] pat;
        pat = 4'b1010;
        repeat (2) step();
        srst = 0;
        nwr = 0;
        // initial sweep: init_done only after the 16th write
        repeat (15) step();
        chk("init_before_last_row", init_done, 0);
        step();
        chk("init_after_sweep", init_done, 1);
        chk("busy_after_sweep", busy, 0);
        chk("first_sweep_writes", nwr, 16);
        // contention: update, lookup, update, lookup
        up_valid = 1; up_addr = 4'd3; up_data = 8'h0F; up_mask = 8'hFF;
        lk_valid = 1; lk_addr = 4'd3; lk_tag = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("contention_wen", sa_wen, pat[3-i]);
            chk("contention_valid", sa_valid, 1);
        end
        step();
        up_valid = 0; lk_valid = 0;
        // read after write
        do_up(4'd5, 8'h21, 8'h21);
        do_lk(4'd5, 1'b1);
        chk("raw_data", m_lk_result, 8'h21);
        // flush with a held lookup
        lk_valid = 1; lk_addr = 4'd5; lk_tag = 1; flush = 1;
        @(negedge clk);
        chk("flush_idle_valid", sa_valid, 0);
        chk("flush_idle_lk", lk_ready, 0);
        step();
        flush = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk("flush_sweep_wr", sa_valid && sa_wen, 1);
            chk("flush_sweep_row", sa_addr, i);
            chk("flush_sweep_lk", lk_ready, 0);
        end
        @(negedge clk);
        chk("flush_first_run_lk", lk_ready, 1);
        step();
        lk_valid = 0;
        chk("flush_row_cleared", m_lk_result, 8'h00);
        // halt at sweep row 7
        srst = 1;
        step();
        srst = 0;
        nwr = 0;
        repeat (7) step();
        sa_ready = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("halt_valid", sa_valid, 0);
            step();
        end
        sa_ready = 1;
        @(negedge clk);
        chk("halt_resume_row", sa_addr, 7);
        chk("halt_resume_valid", sa_valid, 1);
        wait_init();
        chk("halt_total_writes", nwr, 16);
        // reset at sweep row 9
        srst = 1;
        step();
        srst = 0;
        repeat (9) step();
        srst = 1;
        @(negedge clk);
        chk("midsweep_rst_valid", sa_valid, 0);
        chk("midsweep_rst_mask", sa_wmask, 0);
        step();
        srst = 0;
        @(negedge clk);
        chk("midsweep_restart_row", sa_addr, 0);
        chk("midsweep_restart_init", init_done, 0);
        wait_init();
        // reset during a request burst
        up_valid = 1; up_addr = 4'd2; up_data = 8'h55; up_mask = 8'h0F;
        lk_valid = 1; lk_addr = 4'd2; lk_tag = 0;
        repeat (2) step();
        srst = 1;
        @(negedge clk);
        chk("midrun_rst_up", up_ready, 0);
        chk("midrun_rst_lk", lk_ready, 0);
        chk("midrun_rst_valid", sa_valid, 0);
        step();
        srst = 0; up_valid = 0; lk_valid = 0;
        @(negedge clk);
        chk("midrun_restart_init", init_done, 0);
        chk("midrun_restart_busy", busy, 1);
        wait_init();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule
